// File: rtl/chunk_serial_adder_pkg.sv
// Shared definitions for the chunk-serial wide adder: default geometry,
// derived widths and the controller state encoding.
package chunk_serial_adder_pkg;

    localparam int DEF_CHUNK  = 10;
    localparam int DEF_NCHUNK = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Total operand width for a given slice geometry.
    function automatic int calc_w(input int chunk, input int nchunk);
        return chunk * nchunk;
    endfunction

    // Slice counter width; never narrower than one bit.
    function automatic int cnt_width(input int nchunk);
        return (nchunk <= 2) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/chunk_serial_adder_if.sv
// Request/result bundle of the chunk-serial adder. The requester drives the
// operands and START; the adder returns BUSY, the DONE pulse and the result.
interface chunk_serial_adder_if #(
    parameter int W = 40
);
    logic         START;
    logic [W:1]   A;
    logic [W:1]   B;
    logic         CIN;
    logic         BUSY;
    logic         DONE;
    logic [W:1]   SUM;
    logic         COUT;

    modport master (
        output START, A, B, CIN,
        input  BUSY, DONE, SUM, COUT
    );

    modport slave (
        input  START, A, B, CIN,
        output BUSY, DONE, SUM, COUT
    );
endinterface

// File: rtl/RCA_p.sv
// Exact SIZE-bit ripple-carry adder; the only arithmetic element of the
// chunk-serial adder, reused once per slice.
module RCA_p #(
    parameter int SIZE = 4
) (
    input  logic [SIZE:1] A,
    input  logic [SIZE:1] B,
    input  logic          CIN,
    output logic [SIZE:1] SUM,
    output logic          COUT
);

    logic [SIZE:0] carry;

    // Ripple the carry from bit 1 upwards, one full adder per bit.
    always_comb begin
        // NOTE: every combinational output gets a default before the loop so
        // no path leaves it unassigned and no latch is inferred.
        carry    = '0;
        SUM      = '0;
        carry[0] = CIN;
        for (int i = 1; i <= SIZE; i++) begin
            SUM[i]   = A[i] ^ B[i] ^ carry[i-1];
            carry[i] = (A[i] & B[i]) | (carry[i-1] & (A[i] ^ B[i]));
        end
        COUT = carry[SIZE];
    end

endmodule

// File: rtl/chunk_serial_adder.sv
// Wide adder that reuses one CHUNK-bit ripple stage over NCHUNK cycles,
// least-significant slice first, with the inter-slice carry held in a flop.
module chunk_serial_adder
    import chunk_serial_adder_pkg::*;
#(
    parameter int CHUNK  = DEF_CHUNK,
    parameter int NCHUNK = DEF_NCHUNK
) (
    input  logic                 CLK,
    input  logic                 RST,
    chunk_serial_adder_if.slave  bus
);

    localparam int W  = calc_w(CHUNK, NCHUNK);
    localparam int CW = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    // Controller state and output registers.
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic [W:1]    sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          done_q, done_d;

    // Datapath registers.
    logic [W:1]    a_q, a_d;
    logic [W:1]    b_q, b_d;
    logic [W:1]    shadow_q, shadow_d;

    // Shared slice adder.
    logic [CHUNK:1] rca_sum;
    logic           rca_cout;

    RCA_p #(.SIZE(CHUNK)) u_rca (
        .A    (a_q[CHUNK:1]),
        .B    (b_q[CHUNK:1]),
        .CIN  (carry_q),
        .SUM  (rca_sum),
        .COUT (rca_cout)
    );

    // Next-state and datapath update: accept in IDLE, one slice per RUN cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        done_d   = 1'b0;
        a_d      = a_q;
        b_d      = b_q;
        shadow_d = shadow_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    carry_d = bus.CIN;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Place this slice's sum at its final position in the result.
                for (int i = 0; i < NCHUNK; i++) begin
                    if (cnt_q == CW'(i)) begin
                        shadow_d[i*CHUNK+1 +: CHUNK] = rca_sum;
                    end
                end
                carry_d = rca_cout;
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    sum_d   = shadow_d;
                    cout_d  = rca_cout;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    // Operand and shadow registers; always loaded before being consumed.
    always_ff @(posedge CLK) begin
        // NOTE: these wide datapath registers are deliberately not reset; they
        // are fully written on acceptance or slice-by-slice before any use.
        a_q      <= a_d;
        b_q      <= b_d;
        shadow_q <= shadow_d;
    end

    assign bus.BUSY = (state_q == ST_RUN);
    assign bus.DONE = done_q;
    assign bus.SUM  = sum_q;
    assign bus.COUT = cout_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Self-checking bench for chunk_serial_adder: directed scenarios plus random
// operands on a 10x4 instance and a random run on an 8x2 instance.
module tb_chunk_serial_adder;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    chunk_serial_adder_if #(.W(40)) bus0 ();
    chunk_serial_adder_if #(.W(16)) bus1 ();

    chunk_serial_adder #(.CHUNK(10), .NCHUNK(4)) dut0 (
        .CLK (clk),
        .RST (rst),
        .bus (bus0)
    );

    chunk_serial_adder #(.CHUNK(8), .NCHUNK(2)) dut1 (
        .CLK (clk),
        .RST (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are stable 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [40:0] ref40(input logic [39:0] a, input logic [39:0] b,
                                          input logic cin);
        return {1'b0, a} + {1'b0, b} + 41'(cin);
    endfunction

    function automatic logic [39:0] rand40();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return r[39:0];
        endcase
    endfunction

    // One transaction on the 10x4 instance: latency, pulse width and result.
    task automatic run_op(input logic [39:0] a, input logic [39:0] b, input logic cin,
                          input string name);
        logic [40:0] exp;
        int lat;
        exp = ref40(a, b, cin);
        bus0.A = a; bus0.B = b; bus0.CIN = cin; bus0.START = 1'b1;
        tick();
        bus0.START = 1'b0;
        checks++;
        if (bus0.BUSY !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_accept: got %b expected 1", name, bus0.BUSY);
        end
        lat = 0;
        while (bus0.DONE !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (bus0.DONE !== 1'b1) begin
            errors++; $display("FAIL %s done_timeout: got no DONE expected DONE after 4 edges", name);
        end else begin
            if (lat !== 4) begin
                errors++; $display("FAIL %s latency: got %0d expected 4", name, lat);
            end
            checks++;
            if (bus0.SUM !== exp[39:0]) begin
                errors++; $display("FAIL %s sum: got %h expected %h", name, bus0.SUM, exp[39:0]);
            end
            checks++;
            if (bus0.COUT !== exp[40]) begin
                errors++; $display("FAIL %s cout: got %b expected %b", name, bus0.COUT, exp[40]);
            end
        end
        tick();
        checks++;
        if (bus0.DONE !== 1'b0 || bus0.SUM !== exp[39:0]) begin
            errors++; $display("FAIL %s pulse_hold: got done=%b sum=%h expected done=0 sum=%h",
                               name, bus0.DONE, bus0.SUM, exp[39:0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.START = 1'b0; bus0.A = '0; bus0.B = '0; bus0.CIN = 1'b0;
        bus1.START = 1'b0; bus1.A = '0; bus1.B = '0; bus1.CIN = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if ({bus0.BUSY, bus0.DONE, bus0.COUT} !== 3'b000 || bus0.SUM !== 40'h0) begin
            errors++; $display("FAIL reset_dut0: got busy=%b done=%b cout=%b sum=%h expected all 0",
                               bus0.BUSY, bus0.DONE, bus0.COUT, bus0.SUM);
        end
        checks++;
        if ({bus1.BUSY, bus1.DONE, bus1.COUT} !== 3'b000 || bus1.SUM !== 16'h0) begin
            errors++; $display("FAIL reset_dut1: got busy=%b done=%b cout=%b sum=%h expected all 0",
                               bus1.BUSY, bus1.DONE, bus1.COUT, bus1.SUM);
        end
        tick();
    endtask

    task automatic test_full_ripple();
        run_op(40'h00_0000_0001, 40'hFF_FFFF_FFFF, 1'b0, "full_ripple");
    endtask

    task automatic test_carry_in();
        run_op(40'h0, 40'h0, 1'b1, "cin_zero");
        run_op(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b1, "cin_ones");
    endtask

    task automatic test_ignored_start();
        logic [40:0] exp;
        exp = ref40(40'h12_3456_789A, 40'h0F_0F0F_0F0F, 1'b0);
        bus0.A = 40'h12_3456_789A; bus0.B = 40'h0F_0F0F_0F0F; bus0.CIN = 1'b0; bus0.START = 1'b1;
        tick();                                   // E0
        bus0.START = 1'b0;
        tick();                                   // E1
        bus0.A = 40'hAA_AAAA_AAAA; bus0.B = 40'h55_5555_5555; bus0.CIN = 1'b1; bus0.START = 1'b1;
        tick();                                   // E2: START must be ignored
        bus0.START = 1'b0;
        for (int e = 2; e <= 3; e++) begin
            checks++;
            if (bus0.BUSY !== 1'b1 || bus0.DONE !== 1'b0) begin
                errors++; $display("FAIL ignored_start_busy_e%0d: got busy=%b done=%b expected busy=1 done=0",
                                   e, bus0.BUSY, bus0.DONE);
            end
            tick();
        end
        // Now just after E4.
        checks++;
        if (bus0.DONE !== 1'b1 || bus0.SUM !== exp[39:0] || bus0.COUT !== exp[40]) begin
            errors++; $display("FAIL ignored_start_result: got done=%b sum=%h cout=%b expected done=1 sum=%h cout=%b",
                               bus0.DONE, bus0.SUM, bus0.COUT, exp[39:0], exp[40]);
        end
        tick();
        checks++;
        if (bus0.BUSY !== 1'b0 || bus0.DONE !== 1'b0) begin
            errors++; $display("FAIL ignored_start_not_queued: got busy=%b done=%b expected 0 0",
                               bus0.BUSY, bus0.DONE);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        bus0.A = 40'h33_3333_3333; bus0.B = 40'h44_4444_4444; bus0.CIN = 1'b1; bus0.START = 1'b1;
        tick();                                   // E0
        bus0.START = 1'b0;
        tick();                                   // E1
        rst = 1'b1;
        tick();                                   // E2 with reset
        rst = 1'b0;
        checks++;
        if ({bus0.BUSY, bus0.DONE, bus0.COUT} !== 3'b000 || bus0.SUM !== 40'h0) begin
            errors++; $display("FAIL reset_mid: got busy=%b done=%b cout=%b sum=%h expected all 0",
                               bus0.BUSY, bus0.DONE, bus0.COUT, bus0.SUM);
        end
        stray = 0;
        repeat (8) begin
            tick();
            if (bus0.DONE !== 1'b0 || bus0.BUSY !== 1'b0) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++; $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", stray);
        end
    endtask

    task automatic test_back_to_back();
        logic [40:0] accepted[$];
        logic [40:0] exp;
        logic [39:0] last_sum;
        int          k;
        last_sum = bus0.SUM;
        for (k = 0; k < 15; k++) begin
            bus0.A = rand40(); bus0.B = rand40(); bus0.CIN = 1'($urandom_range(0, 1));
            bus0.START = 1'b1;
            // One sum every five cycles: accepted on E0, E5, E10.
            if (k % 5 == 0) accepted.push_back(ref40(bus0.A, bus0.B, bus0.CIN));
            tick();                               // edge Ek
            checks++;
            if (bus0.DONE !== (k % 5 == 4)) begin
                errors++; $display("FAIL b2b_done_e%0d: got %b expected %b", k, bus0.DONE, (k % 5 == 4));
            end
            if (k % 5 == 4) begin
                exp = accepted.pop_front();
                checks++;
                if (bus0.SUM !== exp[39:0] || bus0.COUT !== exp[40]) begin
                    errors++; $display("FAIL b2b_result_e%0d: got sum=%h cout=%b expected sum=%h cout=%b",
                                       k, bus0.SUM, bus0.COUT, exp[39:0], exp[40]);
                end
                last_sum = exp[39:0];
            end else begin
                checks++;
                if (bus0.SUM !== last_sum) begin
                    errors++; $display("FAIL b2b_hold_e%0d: got %h expected %h", k, bus0.SUM, last_sum);
                end
            end
        end
        bus0.START = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_random();
        int bad;
        logic [40:0] exp;
        int lat;
        logic [39:0] a, b;
        logic cin;
        bad = 0;
        for (int n = 0; n < 1000; n++) begin
            a = rand40(); b = rand40(); cin = 1'($urandom_range(0, 1));
            exp = ref40(a, b, cin);
            bus0.A = a; bus0.B = b; bus0.CIN = cin; bus0.START = 1'b1;
            tick();
            bus0.START = 1'b0;
            lat = 0;
            while (bus0.DONE !== 1'b1 && lat < 20) begin
                tick();
                lat++;
            end
            checks++;
            if (bus0.DONE !== 1'b1 || lat !== 4 || bus0.SUM !== exp[39:0] || bus0.COUT !== exp[40]) begin
                errors++;
                if (bad < 5)
                    $display("FAIL random10x4_%0d: got lat=%0d sum=%h cout=%b expected lat=4 sum=%h cout=%b",
                             n, lat, bus0.SUM, bus0.COUT, exp[39:0], exp[40]);
                bad++;
            end
        end
        tick();
    endtask

    task automatic test_random_small();
        int bad;
        logic [16:0] exp;
        int lat;
        logic [15:0] a, b;
        logic cin;
        bad = 0;
        for (int n = 0; n < 1000; n++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
            exp = {1'b0, a} + {1'b0, b} + 17'(cin);
            bus1.A = a; bus1.B = b; bus1.CIN = cin; bus1.START = 1'b1;
            tick();
            bus1.START = 1'b0;
            lat = 0;
            while (bus1.DONE !== 1'b1 && lat < 20) begin
                tick();
                lat++;
            end
            checks++;
            if (bus1.DONE !== 1'b1 || lat !== 2 || bus1.SUM !== exp[15:0] || bus1.COUT !== exp[16]) begin
                errors++;
                if (bad < 5)
                    $display("FAIL random8x2_%0d: got lat=%0d sum=%h cout=%b expected lat=2 sum=%h cout=%b",
                             n, lat, bus1.SUM, bus1.COUT, exp[15:0], exp[16]);
                bad++;
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_ripple();
        test_carry_in();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_random_small();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chunk_serial_adder.md
# chunk_serial_adder

Multi-cycle wide adder that reuses one `RCA_p` ripple-carry stage over several clock cycles. It adds two `CHUNK*NCHUNK`-bit operands one `CHUNK`-bit slice per cycle, least-significant slice first. Between slices it carries the ripple carry in a register. It sits directly upstream of `RCA_p`: it registers the operands, feeds each slice and carry-in to the adder, and collects the slice sums and the carry-out. Use it wherever a wide sum is needed with the area of a single narrow adder.

## Interface
Parameters:
- `CHUNK`, default 10: slice width; also the `SIZE` of the embedded `RCA_p`.
- `NCHUNK`, default 4: number of slices, minimum 2. `W = CHUNK*NCHUNK` (40 by default).

Ports:
- `CLK`, input, 1: single clock, rising edge.
- `RST`, input, 1: reset, synchronous and active-high.
- `START`, input, 1: request. Sampled only when idle.
- `A`, input, `[W:1]`: operand A. Sampled on the accepting edge.
- `B`, input, `[W:1]`: operand B. Sampled on the accepting edge.
- `CIN`, input, 1: carry-in. Sampled on the accepting edge.
- `BUSY`, output, 1: high while a sum is in progress.
- `DONE`, output, 1: one-cycle pulse; `SUM` and `COUT` are valid in that cycle.
- `SUM`, output, `[W:1]`: result. Holds its value until the next completion.
- `COUT`, output, 1: final carry-out. Holds its value like `SUM`.

## Operation
- States:
  - `IDLE`: `BUSY`=0.
  - `RUN`: `BUSY`=1.
- Slice counter `cnt`: range 0..`NCHUNK`-1, width `clog2(NCHUNK)` (minimum 1).
- IDLE and `START`=1:
  - latch `A` and `B` into shift registers;
  - carry register ← `CIN`;
  - `cnt` ← 0;
  - go to RUN.
- IDLE and `START`=0: no change.
- RUN, each edge:
  - the `RCA_p` inputs are the low `CHUNK` bits of the A/B shift registers and the carry register;
  - the `RCA_p` `SUM` is written into slice `cnt` of a shadow result register (bits `cnt*CHUNK+1` … `(cnt+1)*CHUNK`);
  - carry register ← `RCA_p` `COUT`;
  - both operand registers shift right by `CHUNK`;
  - `cnt` increments.
- RUN with `cnt`=`NCHUNK`-1, same edge:
  - `SUM` ← completed shadow result, including this final slice;
  - `COUT` ← this slice's carry-out;
  - `DONE` ← 1;
  - state ← IDLE.
- `DONE` is registered and deasserts on the following edge unless another completion occurs.
- `START` while in RUN is ignored. It is not queued and the operands are not resampled.
- Arithmetic:
  - result = `A + B + CIN` modulo 2^W;
  - `COUT` is bit W of the unrounded sum;
  - the `RCA_p` instance is exact, so the result equals a W-bit `RCA_p`.
- `RST`=1 at any edge:
  - state IDLE, `cnt` 0, carry register 0;
  - `BUSY`, `DONE`, `SUM`, `COUT` all 0;
  - any sum in progress is abandoned and produces no `DONE`;
  - `RST` takes priority over `START`.

## Timing
- Reset values: `BUSY`=0, `DONE`=0, `SUM`=0, `COUT`=0.
- Latency:
  - `START` is accepted on edge E0;
  - `BUSY` is high from E0 to E`NCHUNK`;
  - `DONE`, `SUM` and `COUT` update on edge E`NCHUNK`.
- Throughput: the next `START` is accepted on E`NCHUNK`+1, i.e. in the `DONE` cycle. One sum every `NCHUNK`+1 cycles.
- `SUM` and `COUT` do not change during RUN; they show the previous result until completion.
- Critical path: one `CHUNK`-bit ripple plus the slice-select logic. No path spans W bits.

## Structure
- Shared package (or include):
  - `W` derivation;
  - `clog2`-based counter width;
  - state encoding `ST_IDLE`/`ST_RUN`.
- Sub-module: one instance of `RCA_p` with `#(.SIZE(CHUNK))`. No other sub-modules.
- Datapath registers:
  - two W-bit operand shift registers;
  - W-bit shadow result;
  - 1-bit carry register;
  - output registers.

## Test plan
Defaults: `CHUNK`=10, `NCHUNK`=4.
- **Full ripple:** `A`=40'h00_0000_0001, `B`=40'hFF_FFFF_FFFF, `CIN`=0 → `SUM`=0, `COUT`=1. `DONE` is high exactly 4 cycles after the `START` edge, for one cycle.
- **Carry-in only:** `A`=`B`=0, `CIN`=1 → `SUM`=1, `COUT`=0. `A`=`B`=40'hFF_FFFF_FFFF, `CIN`=1 → `SUM`=40'hFF_FFFF_FFFF, `COUT`=1.
- **Ignored START:** `START` again at E2 with different operands → it is ignored; the first result is delivered on E4 and `BUSY` stays high throughout.
- **Reset mid-operation:** `RST` asserted at E2 → on the next cycle `BUSY`, `DONE`, `SUM`, `COUT` are all 0, and no `DONE` follows.
- **Back-to-back:** `START` held high continuously → acceptances on E0, E5, E10. `DONE` pulses on E4, E9, E14. `SUM` holds each result between pulses.
- **Random:** 1000 random `A`, `B`, `CIN` against the reference `A+B+CIN` → `SUM` and `COUT` match. Repeat with `CHUNK`=8, `NCHUNK`=2.
